// File: rtl/imhotep_pkg.sv
// Shared core types for the imhotep LSU and its data-memory responder.
// Holds the LSU op encoding, request struct and responder FSM states.
package imhotep_pkg;

    localparam int XLEN         = 32;
    localparam int RAM_WIDTH    = 16;
    localparam int LSU_OP_WIDTH = 4;

    typedef enum logic [LSU_OP_WIDTH-1:0] {
        LSU_NOP = 4'h0,
        LSU_LB  = 4'h1,
        LSU_LH  = 4'h2,
        LSU_LW  = 4'h3,
        LSU_LBU = 4'h4,
        LSU_LHU = 4'h5,
        LSU_SB  = 4'h6,
        LSU_SH  = 4'h7,
        LSU_SW  = 4'h8
    } op_lsu_e;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_ACC0,
        DMEM_ACC1,
        DMEM_RESP
    } dmem_state_e;

    typedef struct packed {
        op_lsu_e          op;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  wdata;
    } lsu_req_t;

    // Misaligned, out-of-range or unknown-op requests are answered with an error.
    function automatic logic lsu_req_error(input logic [LSU_OP_WIDTH-1:0] op,
                                           input logic [XLEN-1:0]         addr,
                                           input int unsigned             depth_hw);
        logic [XLEN-1:0] limit;
        logic            bad;
        limit = XLEN'(2 * depth_hw);
        bad   = (addr >= limit);
        case (op)
            LSU_LW, LSU_SW:          bad = bad | (addr[1:0] != 2'b00);
            LSU_LH, LSU_LHU, LSU_SH: bad = bad | addr[0];
            LSU_LB, LSU_LBU, LSU_SB,
            LSU_NOP:                 bad = bad;
            default:                 bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/imhotep_ram_1rw16.sv
// Single-port halfword RAM with per-byte write enables and synchronous read.
// Read data updates only on read accesses and holds otherwise.
module imhotep_ram_1rw16
    import imhotep_pkg::*;
#(
    parameter int DEPTH_HW = 1024
) (
    input  logic                        clk_i,
    input  logic                        en,
    input  logic                        we,
    input  logic [1:0]                  be,
    input  logic [$clog2(DEPTH_HW)-1:0] addr,
    input  logic [RAM_WIDTH-1:0]        wdata,
    output logic [RAM_WIDTH-1:0]        rdata
);

    logic [RAM_WIDTH-1:0] mem [DEPTH_HW];

    // NOTE: storage arrays carry no reset; resetting them would prevent RAM macro inference.
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                if (be[0]) mem[addr][7:0]  <= wdata[7:0];
                if (be[1]) mem[addr][15:8] <= wdata[15:8];
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/imhotep_dmem_responder.sv
// Memory-side responder for the LSU: one request at a time, served from a
// 16-bit RAM in one or two halfword accesses, with a registered response.
module imhotep_dmem_responder
    import imhotep_pkg::*;
#(
    parameter int DEPTH_HW = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [LSU_OP_WIDTH-1:0] req_op_i,
    input  logic [XLEN-1:0]         req_addr_i,
    input  logic [XLEN-1:0]         req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [XLEN-1:0]         rsp_rdata_o,
    output logic                    rsp_err_o
);

    localparam int HW_AW = $clog2(DEPTH_HW);

    dmem_state_e          state_q, state_d;
    lsu_req_t             req_q;
    logic                 err_q;
    logic [RAM_WIDTH-1:0] lo_q;
    logic                 req_fire, req_err, is_store, is_word;
    logic                 ram_en, ram_we;
    logic [1:0]           ram_be;
    logic [HW_AW-1:0]     idx, ram_addr;
    logic [RAM_WIDTH-1:0] ram_wdata, ram_rdata;
    logic [7:0]           sel_byte;
    logic [XLEN-1:0]      rdata_d;
    logic                 unused_addr_hi;

    assign req_fire       = req_valid_i && req_ready_o;
    assign req_err        = lsu_req_error(req_op_i, req_addr_i, DEPTH_HW);
    assign idx            = req_q.addr[HW_AW:1];
    assign is_word        = (req_q.op == LSU_LW) || (req_q.op == LSU_SW);
    assign is_store       = (req_q.op == LSU_SB) || (req_q.op == LSU_SH) || (req_q.op == LSU_SW);
    assign unused_addr_hi = ^req_q.addr[XLEN-1:HW_AW+1];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= DMEM_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: each combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE: if (req_fire && (req_op_i != LSU_NOP))
                           state_d = req_err ? DMEM_RESP : DMEM_ACC0;
            DMEM_ACC0: state_d = is_word ? DMEM_ACC1 : DMEM_RESP;
            DMEM_ACC1: state_d = DMEM_RESP;
            DMEM_RESP: if (rsp_valid_o && rsp_ready_i) state_d = DMEM_IDLE;
            default:   state_d = DMEM_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == DMEM_IDLE);
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_be      = 2'b11;
        ram_addr    = idx;
        ram_wdata   = req_q.wdata[15:0];
        case (state_q)
            DMEM_ACC0: begin
                ram_en = 1'b1;
                ram_we = is_store;
                if (req_q.op == LSU_SB) begin
                    ram_be    = req_q.addr[0] ? 2'b10 : 2'b01;
                    ram_wdata = {req_q.wdata[7:0], req_q.wdata[7:0]};
                end
            end
            DMEM_ACC1: begin
                ram_en    = 1'b1;
                ram_we    = is_store;
                ram_addr  = idx + HW_AW'(1);
                ram_wdata = req_q.wdata[31:16];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= '0;
            err_q <= 1'b0;
            lo_q  <= '0;
        end else begin
            if (req_fire) begin
                req_q <= '{op: op_lsu_e'(req_op_i), addr: req_addr_i, wdata: req_wdata_i};
                err_q <= req_err;
            end
            if (state_q == DMEM_ACC1) lo_q <= ram_rdata;
        end
    end

    // Narrow loads read the single access; words pair the captured low half with the fresh high half.
    assign sel_byte = req_q.addr[0] ? ram_rdata[15:8] : ram_rdata[7:0];

    always_comb begin
        rdata_d = '0;
        case (req_q.op)
            LSU_LB:  rdata_d = {{24{sel_byte[7]}}, sel_byte};
            LSU_LBU: rdata_d = {24'h0, sel_byte};
            LSU_LH:  rdata_d = {{16{ram_rdata[15]}}, ram_rdata};
            LSU_LHU: rdata_d = {16'h0, ram_rdata};
            LSU_LW:  rdata_d = {ram_rdata, lo_q};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (state_q == DMEM_RESP) begin
            if (!rsp_valid_o) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= err_q;
                rsp_rdata_o <= err_q ? '0 : rdata_d;
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                rsp_err_o   <= 1'b0;
                rsp_rdata_o <= '0;
            end
        end
    end

    imhotep_ram_1rw16 #(.DEPTH_HW(DEPTH_HW)) u_ram (
        .clk_i (clk_i),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
